bus_initiator: RTL



---
 rtl/bus_initiator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bus_initiator.sv
// bus_initiator
//   Turns a ready/valid command stream into single-cycle strobes on the
//   memory-mapped peripheral bus, and returns read results (or a timeout
//   indication) on a ready/valid response stream. Only one transaction is
//   in flight at a time. Writes are posted and never produce a response.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_*                 command in (valid/ready, write flag, addr, data, byte enables)
//   rsp_*                 read response out (valid/ready, data, timeout flag)
//   bus_addr/_write_data/_byte_enable  latched command fields, held until next command
//   bus_write_req/_read_req            one-cycle request strobes
//   bus_read_data/_valid  read return from the responder
module bus_initiator #(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_data,
  input  logic [3:0]            cmd_byte_enable,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_write_data,
  output logic [3:0]            bus_byte_enable,
  output logic                  bus_write_req,
  output logic                  bus_read_req,
  input  logic [31:0]           bus_read_data,
  input  logic                  bus_read_data_valid
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, READ_WAIT, RESP} state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
    logic [3:0]            be;
  } cmd_t;

  state_e         state_q, state_d;
  cmd_t           cmd_q, cmd_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic           rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d   = '{write: cmd_write, addr: cmd_addr, data: cmd_data, be: cmd_byte_enable};
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_q.write) begin
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        // data arriving on the last allowed cycle still wins over the timeout
        if (bus_read_data_valid) begin
          rsp_data_d    = bus_read_data;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  // Outputs decode from registers only; reset clears state_q so the strobes
  // drop asynchronously with reset_n.
  assign cmd_ready       = (state_q == IDLE);
  assign rsp_valid       = (state_q == RESP);
  assign bus_write_req   = (state_q == ISSUE) &&  cmd_q.write;
  assign bus_read_req    = (state_q == ISSUE) && !cmd_q.write;
  assign rsp_data        = rsp_data_q;
  assign rsp_timeout     = rsp_timeout_q;
  assign bus_addr        = cmd_q.addr;
  assign bus_write_data  = cmd_q.data;
  assign bus_byte_enable = cmd_q.be;

endmodule
